flash_spi_initiator: RTL and testbench

Byte-oriented SPI mode-0 initiator that drives one flash device's clock, chip-select and MOSI and samples its MISO. The RAID controller core instantiates one per flash port, main and secondary. The core issues bytes through a valid/ready command interface and receives the returned bytes as single-cycle pulses. This block is the flash-facing counterpart of the host-facing SPI responders: it generates SCLK and CS rather than following them.

---
 rtl/flash_spi_initiator.sv | 168 ++++++++++++++++
 tb/tb_flash_spi_initiator.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_spi_initiator.sv
// flash_spi_initiator
//   Byte-oriented SPI mode-0 initiator for one flash device. The controller
//   core hands bytes over a valid/ready command interface. Each returned byte
//   comes back as a single-cycle rx_valid pulse. The block generates SCLK and
//   CS itself.
//
// Parameters
//   CLK_DIV   SCLK half-period in clk cycles (1..255)
//   CS_GAP    minimum clk cycles CS stays high between transactions (1..255)
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_data is sent MSB first
//   cmd_last            release CS after this byte
//   abort               terminate the current transaction (SHIFT/HOLD only)
//   rx_valid, rx_data   one-cycle pulse with the byte sampled from MISO
//   busy                high whenever the block is not idle
//   spi_clk, spi_cs_n,
//   spi_mosi, spi_miso  flash pins (MISO is already synchronised upstream)
module flash_spi_initiator #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    input  logic       cmd_last,
    output logic       cmd_ready,
    input  logic       abort,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       spi_clk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    logic [1:0] state;
    logic [7:0] div_cnt;
    logic [3:0] half_cnt;
    logic [7:0] gap_cnt;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic       last_q;
    logic       ready_en;
    logic       take;

    // ready_en holds cmd_ready low while rst is asserted and releases it on
    // the first clock edge after reset is removed.
    assign cmd_ready = ready_en && ((state == ST_IDLE) || (state == ST_HOLD));
    assign busy      = (state != ST_IDLE);
    assign take      = cmd_valid && cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            half_cnt <= '0;
            gap_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            last_q   <= 1'b0;
            ready_en <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            spi_clk  <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // abort is ignored here; only the handshake matters
                    if (take) begin
                        state    <= ST_SHIFT;
                        spi_cs_n <= 1'b0;
                        spi_clk  <= 1'b0;
                        spi_mosi <= cmd_data[7];
                        tx_shift <= {cmd_data[6:0], 1'b0};
                        last_q   <= cmd_last;
                        div_cnt  <= '0;
                        half_cnt <= '0;
                        rx_shift <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state    <= ST_GAP;
                        spi_cs_n <= 1'b1;
                        spi_clk  <= 1'b0;
                        gap_cnt  <= '0;
                        rx_shift <= '0;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        half_cnt <= half_cnt + 4'd1;
                        spi_clk  <= ~spi_clk;
                        if (!spi_clk) begin
                            // rising SCLK edge: capture MISO
                            rx_shift <= {rx_shift[6:0], spi_miso};
                        end else if (half_cnt == 4'd15) begin
                            // 16th half-period: byte complete, MOSI keeps bit 0
                            rx_valid <= 1'b1;
                            rx_data  <= rx_shift;
                            spi_clk  <= 1'b0;
                            if (last_q) begin
                                state    <= ST_GAP;
                                spi_cs_n <= 1'b1;
                                gap_cnt  <= '0;
                            end else begin
                                state <= ST_HOLD;
                            end
                        end else begin
                            // falling SCLK edge: present next MOSI bit
                            spi_mosi <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    // abort outranks a simultaneous accept; that byte is dropped
                    if (abort) begin
                        state    <= ST_GAP;
                        spi_cs_n <= 1'b1;
                        spi_clk  <= 1'b0;
                        gap_cnt  <= '0;
                        rx_shift <= '0;
                    end else if (take) begin
                        state    <= ST_SHIFT;
                        spi_cs_n <= 1'b0;
                        spi_clk  <= 1'b0;
                        spi_mosi <= cmd_data[7];
                        tx_shift <= {cmd_data[6:0], 1'b0};
                        last_q   <= cmd_last;
                        div_cnt  <= '0;
                        half_cnt <= '0;
                        rx_shift <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    spi_cs_n <= 1'b1;
                    spi_clk  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_spi_initiator.sv
// tb_flash_spi_initiator
//   Directed bench for flash_spi_initiator with CLK_DIV=2, CS_GAP=4.
//   MISO source: 0 = loopback from MOSI, 1 = constant 1, 2 = JEDEC flash model.
module tb_flash_spi_initiator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_last = 1'b0;
    logic       abort = 1'b0;
    logic       cmd_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       spi_clk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int miso_mode = 0;

    int         rise_q[$];
    int         rxc_q[$];
    logic [7:0] rx_q[$];
    int         csr_q[$];
    logic       p_clk = 1'b0;
    logic       p_cs = 1'b1;

    logic [7:0] resp [4] = '{8'h00, 8'hEF, 8'h40, 8'h18};
    int         fbit = 0;
    logic       flash_bit;

    flash_spi_initiator #(.CLK_DIV(2), .CS_GAP(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_last(cmd_last),
        .cmd_ready(cmd_ready), .abort(abort),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
        .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // flash model: shifts its response out MSB first, one bit per SCLK rise
    always @(negedge spi_cs_n) fbit = 0;
    always @(posedge spi_clk) fbit++;
    always_comb begin
        int b;
        b = fbit / 8;
        if (b > 3) b = 3;
        flash_bit = resp[b][7 - (fbit % 8)];
    end
    assign spi_miso = (miso_mode == 0) ? spi_mosi :
                      (miso_mode == 1) ? 1'b1 : flash_bit;

    // event log sampled on the inactive edge
    always @(negedge clk) begin
        if (!rst) begin
            if (spi_clk === 1'b1 && p_clk === 1'b0) rise_q.push_back(cyc);
            if (rx_valid === 1'b1) begin
                rx_q.push_back(rx_data);
                rxc_q.push_back(cyc);
            end
            if (spi_cs_n === 1'b1 && p_cs === 1'b0) csr_q.push_back(cyc);
        end
        p_clk = spi_clk;
        p_cs  = spi_cs_n;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        rise_q.delete();
        rxc_q.delete();
        rx_q.delete();
        csr_q.delete();
    endtask

    // Called at a negedge. Returns the accept cycle (or -1 on timeout) and
    // leaves the caller at the negedge of cycle t+1 with scrambled inputs.
    task automatic send(input logic [7:0] d, input logic l, output int t);
        t = -1;
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_last  = l;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready === 1'b1) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = ~d;
        cmd_last  = ~l;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b want 1", spi_cs_n); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b want 0", spi_clk); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b want 0", spi_mosi); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst = 1'b0;
        step(1);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_loopback();
        int t;
        int bad_cs = 0;
        int bad_rdy = 0;
        int bad_rise = 0;
        logic mosi_first;
        miso_mode = 0;
        clear_log();
        send(8'h9F, 1'b1, t);
        checks++; if (t < 0) begin errors++; $display("FAIL lb_accept: got timeout want accept"); return; end
        mosi_first = spi_mosi;
        for (int i = 1; i <= 40; i++) begin
            if (i <= 37 && spi_cs_n !== ((i <= 32) ? 1'b0 : 1'b1)) bad_cs++;
            if (cmd_ready !== ((i >= 37) ? 1'b1 : 1'b0)) bad_rdy++;
            step(1);
        end
        checks++; if (mosi_first !== 1'b1) begin errors++; $display("FAIL lb_mosi_bit7: got %b want 1", mosi_first); end
        checks++; if (bad_cs != 0) begin errors++; $display("FAIL lb_cs_window: got %0d bad cycles want 0", bad_cs); end
        checks++; if (bad_rdy != 0) begin errors++; $display("FAIL lb_ready_window: got %0d bad cycles want 0", bad_rdy); end
        checks++; if (rise_q.size() != 8) begin errors++; $display("FAIL lb_rise_count: got %0d want 8", rise_q.size()); end
        for (int k = 0; k < rise_q.size(); k++) if (rise_q[k] != t + 3 + 4 * k) bad_rise++;
        checks++; if (bad_rise != 0) begin errors++; $display("FAIL lb_rise_timing: got %0d misplaced want 0", bad_rise); end
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL lb_rx_count: got %0d want 1", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 8'h9F) begin errors++; $display("FAIL lb_rx_data: got %h want 9f", rx_q[0]); end
            checks++; if (rxc_q[0] != t + 33) begin errors++; $display("FAIL lb_rx_time: got %0d want %0d", rxc_q[0] - t, 33); end
        end
        checks++; if (rx_data !== 8'h9F) begin errors++; $display("FAIL lb_rx_hold: got %h want 9f", rx_data); end
    endtask

    task automatic test_jedec();
        int t0, t1, t2, t3;
        miso_mode = 2;
        clear_log();
        send(8'h9F, 1'b0, t0);
        send(8'h00, 1'b0, t1);
        send(8'h00, 1'b0, t2);
        send(8'h00, 1'b1, t3);
        step(40);
        checks++; if (t0 < 0 || t1 - t0 != 33 || t2 - t1 != 33 || t3 - t2 != 33) begin
            errors++; $display("FAIL jedec_spacing: got %0d %0d %0d want 33 33 33", t1 - t0, t2 - t1, t3 - t2); end
        checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL jedec_rx_count: got %0d want 4", rx_q.size()); end
        else begin
            checks++; if (rx_q[1] !== 8'hEF || rx_q[2] !== 8'h40 || rx_q[3] !== 8'h18) begin
                errors++; $display("FAIL jedec_id: got %h %h %h want ef 40 18", rx_q[1], rx_q[2], rx_q[3]); end
            checks++; if (rxc_q[3] != t3 + 33) begin errors++; $display("FAIL jedec_rx_time: got %0d want %0d", rxc_q[3] - t3, 33); end
        end
        checks++; if (csr_q.size() != 1) begin errors++; $display("FAIL jedec_cs_rises: got %0d want 1", csr_q.size()); end
        else begin
            checks++; if (csr_q[0] != t3 + 33) begin errors++; $display("FAIL jedec_cs_release: got %0d want %0d", csr_q[0] - t3, 33); end
        end
    endtask

    task automatic test_hold_stall();
        int t1, t2;
        int bad = 0;
        miso_mode = 0;
        clear_log();
        send(8'hA5, 1'b0, t1);
        step(32);
        for (int i = 0; i < 50; i++) begin
            if (spi_cs_n !== 1'b0 || spi_clk !== 1'b0 || spi_mosi !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b1) bad++;
            step(1);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold_pins: got %0d bad cycles want 0", bad); end
        send(8'h3C, 1'b1, t2);
        step(40);
        checks++; if (t1 < 0 || t2 - t1 != 83) begin errors++; $display("FAIL stall_accept: got %0d want 83", t2 - t1); end
        checks++; if (rx_q.size() != 2 || rise_q.size() != 16) begin
            errors++; $display("FAIL stall_counts: got rx %0d rise %0d want 2 16", rx_q.size(), rise_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h3C) begin errors++; $display("FAIL stall_data: got %h %h want a5 3c", rx_q[0], rx_q[1]); end
            checks++; if (rise_q[8] != t2 + 3 || rxc_q[1] != t2 + 33) begin
                errors++; $display("FAIL stall_timing: got rise %0d rx %0d want 3 33", rise_q[8] - t2, rxc_q[1] - t2); end
        end
    endtask

    task automatic test_abort();
        int t, t2;
        miso_mode = 0;
        clear_log();
        send(8'hC3, 1'b0, t);
        step(14);
        checks++; if (spi_clk !== 1'b1 || cyc != t + 15) begin errors++; $display("FAIL abort_rise4: got sclk %b want 1", spi_clk); end
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checks++; if (spi_cs_n !== 1'b1 || spi_clk !== 1'b0) begin
            errors++; $display("FAIL abort_pins: got cs_n %b sclk %b want 1 0", spi_cs_n, spi_clk); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b want 1", busy); end
        step(3);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_gap_ready: got %b want 0", cmd_ready); end
        step(1);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_return: got %b want 1", cmd_ready); end
        step(30);
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL abort_no_rx: got %0d want 0", rx_q.size()); end
        clear_log();
        send(8'h5A, 1'b1, t2);
        step(40);
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
            errors++; $display("FAIL abort_next_byte: got %0d bytes want one 5a", rx_q.size()); end
    endtask

    task automatic test_abort_accept();
        int t;
        miso_mode = 0;
        clear_log();
        send(8'h11, 1'b0, t);
        step(32);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL aa_hold_ready: got %b want 1", cmd_ready); end
        cmd_valid = 1'b1;
        cmd_data  = 8'h22;
        cmd_last  = 1'b1;
        abort     = 1'b1;
        step(1);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        checks++; if (spi_cs_n !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL aa_gap: got cs_n %b busy %b ready %b want 1 1 0", spi_cs_n, busy, cmd_ready); end
        step(40);
        checks++; if (rise_q.size() != 8) begin errors++; $display("FAIL aa_no_sclk: got %0d rises want 8", rise_q.size()); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h11) begin
            errors++; $display("FAIL aa_dropped: got %0d bytes want one 11", rx_q.size()); end
    endtask

    task automatic test_reset_mid();
        int t, t2;
        miso_mode = 0;
        clear_log();
        send(8'h5A, 1'b1, t);
        step(12);
        rst = 1'b1;
        #1;
        checks++; if (spi_cs_n !== 1'b1 || spi_clk !== 1'b0 || spi_mosi !== 1'b0) begin
            errors++; $display("FAIL rmid_pins: got cs_n %b sclk %b mosi %b want 1 0 0", spi_cs_n, spi_clk, spi_mosi); end
        checks++; if (cmd_ready !== 1'b0 || busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_ctrl: got ready %b busy %b rxv %b want 0 0 0", cmd_ready, busy, rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rmid_rx_data: got %h want 00", rx_data); end
        step(2);
        rst = 1'b0;
        step(1);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_release_ready: got %b want 1", cmd_ready); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rmid_no_rx: got %0d want 0", rx_q.size()); end
        miso_mode = 1;
        clear_log();
        send(8'hA5, 1'b1, t2);
        step(40);
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hFF) begin
            errors++; $display("FAIL rmid_next_byte: got %0d bytes want one ff", rx_q.size()); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_jedec();
        test_hold_stall();
        test_abort();
        test_abort_accept();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
